// File: rtl/tremolo_pkg.sv
// Shared types and constants for the tremolo amplitude-modulation stage.
// Optional macro TREM_DEPTH_RAMP_EN is consumed by tremolo_modulator.sv.
package tremolo_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAIN = 2'd1,
        S_MUL  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    localparam int                GAIN_W     = 17;
    localparam int                GAIN_FRAC  = 15;
    localparam logic [GAIN_W-1:0] GAIN_ONE   = 17'd32768;
    localparam longint            LFO_HALF   = 64'sd1073741824;
    localparam int                ROUND_HALF = 16384;
    localparam int                U_SHIFT    = 16;

endpackage

// File: rtl/tremolo_gain.sv
// Combinational LFO/depth/enable to unsigned Q1.15 gain mapping.
// Maps the nominal LFO range onto u = 0..32768; out-of-range words clamp instead of wrapping.
module tremolo_gain
    import tremolo_pkg::*;
#(
    parameter int LFO_W = 32
) (
    input  logic signed [LFO_W-1:0] lfo_i,
    input  logic        [2:0]       depth_i,
    input  logic                    enable_i,
    output logic        [GAIN_W-1:0] gain_o
);

    logic signed [LFO_W:0]      biased;
    logic signed [LFO_W:0]      shifted;
    logic        [GAIN_W-1:0]   u;
    logic        [GAIN_W-1:0]   span;
    logic        [GAIN_W+2:0]   scaled;

    always_comb begin
        biased  = $signed({lfo_i[LFO_W-1], lfo_i}) + $signed((LFO_W+1)'(LFO_HALF));
        shifted = biased >>> U_SHIFT;
        if (shifted[LFO_W]) begin
            u = '0;
        end else if (shifted > $signed((LFO_W+1)'(GAIN_ONE))) begin
            u = GAIN_ONE;
        end else begin
            u = GAIN_W'(shifted);
        end
        span   = GAIN_ONE - u;
        scaled = {{GAIN_W{1'b0}}, depth_i} * {3'b000, span};
        if (enable_i) begin
            gain_o = GAIN_ONE - GAIN_W'(scaled >> 3);
        end else begin
            gain_o = GAIN_ONE;
        end
    end

endmodule

// File: rtl/tremolo_modulator.sv
// Tremolo stage: capture -> gain -> multiply -> round/saturate, one sample per 4 cycles.
// Define TREM_DEPTH_RAMP_EN to slew the applied depth by one step per accepted sample.
module tremolo_modulator
    import tremolo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LFO_W  = 32,
    parameter int DROP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [LFO_W-1:0]  i_lfo,
    input  logic [2:0]        i_depth,
    input  logic              i_enable,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_valid,
    output logic              o_busy,
    output logic [DROP_W-1:0] o_drop_cnt,
    output logic [1:0]        o_dbg_state
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    // Handshake: i_valid is a one-cycle strobe accepted only in S_IDLE; o_valid is a
    // one-cycle strobe marking a new o_sample, which then holds until the next strobe.

    state_e                     state_q, state_d;
    logic signed [DATA_W-1:0]   sample_q, sample_d;
    logic        [LFO_W-1:0]    lfo_q, lfo_d;
    logic        [2:0]          depth_q, depth_d;
    logic                       enable_q, enable_d;
    logic        [GAIN_W-1:0]   gain_q, gain_d;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic        [DATA_W-1:0]   out_q, out_d;
    logic                       valid_q, valid_d;
    logic        [DROP_W-1:0]   drop_q, drop_d;

    logic        [GAIN_W-1:0]   gain_c;
    logic signed [PROD_W-1:0]   rounded;
    logic signed [PROD_W-1:0]   out_max;
    logic signed [PROD_W-1:0]   out_min;

    tremolo_gain #(
        .LFO_W (LFO_W)
    ) u_gain (
        .lfo_i    ($signed(lfo_q)),
        .depth_i  (depth_q),
        .enable_i (enable_q),
        .gain_o   (gain_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
            lfo_q    <= '0;
            depth_q  <= '0;
            enable_q <= 1'b0;
            gain_q   <= '0;
            prod_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            lfo_q    <= lfo_d;
            depth_q  <= depth_d;
            enable_q <= enable_d;
            gain_q   <= gain_d;
            prod_q   <= prod_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        lfo_d    = lfo_q;
        depth_d  = depth_q;
        enable_d = enable_q;
        gain_d   = gain_q;
        prod_d   = prod_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        drop_d   = drop_q;

        out_max = $signed(PROD_W'((1 << (DATA_W - 1)) - 1));
        out_min = -$signed(PROD_W'(1 << (DATA_W - 1)));
        rounded = (prod_q + $signed(PROD_W'(ROUND_HALF))) >>> GAIN_FRAC;

        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    sample_d = $signed(i_sample);
                    lfo_d    = i_lfo;
                    enable_d = i_enable;
`ifdef TREM_DEPTH_RAMP_EN
                    // depth_q acts as the slewed effective depth: one step toward i_depth.
                    if (i_depth > depth_q) begin
                        depth_d = depth_q + 3'd1;
                    end else if (i_depth < depth_q) begin
                        depth_d = depth_q - 3'd1;
                    end
`else
                    depth_d  = i_depth;
`endif
                    state_d  = S_GAIN;
                end
            end
            S_GAIN: begin
                gain_d  = gain_c;
                state_d = S_MUL;
            end
            S_MUL: begin
                prod_d  = sample_q * $signed({1'b0, gain_q});
                state_d = S_OUT;
            end
            S_OUT: begin
                if (rounded > out_max) begin
                    out_d = DATA_W'(out_max);
                end else if (rounded < out_min) begin
                    out_d = DATA_W'(out_min);
                end else begin
                    out_d = DATA_W'(rounded);
                end
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (i_valid && (state_q != S_IDLE) && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    assign o_sample    = out_q;
    assign o_valid     = valid_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_drop_cnt  = drop_q;
    assign o_dbg_state = state_q;

endmodule
